// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM encoding and tick edge-detector constants for the debouncer
package debounce_pkg;

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_PEND_HIGH   = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_PEND_LOW    = 2'd3;

  // History flop resets high so a strobe already high at reset release is not an edge.
  localparam logic TICK_HIST_RESET = 1'b1;

  // Debounced level implied by an FSM state.
  function automatic logic level_of(input logic [1:0] st);
    return (st == ST_STABLE_HIGH) || (st == ST_PEND_LOW);
  endfunction

endpackage

// File: rtl/debounce_rise_detect.sv
// rtl/debounce_rise_detect.sv - registered one-cycle pulse on a 0->1 transition of din
module rise_detect
  import debounce_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic din_q;

  // Remember the previous sample and emit one pulse per observed rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= TICK_HIST_RESET;
      pulse <= 1'b0;
    end else begin
      din_q <= din;
      pulse <= din & ~din_q;
    end
  end

endmodule

// File: rtl/debouncer.sv
// rtl/debouncer.sv - tick-sampled button debouncer with level and edge outputs
module debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_COUNT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          sync_meta;
  logic          btn_sync;
  logic          tick_pulse;
  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          rise_n, fall_n;

  // Two-flop synchroniser; btn_in is touched nowhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      btn_sync  <= sync_meta;
    end
  end

  rise_detect u_tick_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tick_in),
    .pulse (tick_pulse)
  );

  // cnt never exceeds STABLE_COUNT-1, so the increment always fits in CW bits.
  assign cnt_inc = cnt + ONE;

  // Next-state logic: advance only on tick_pulse, a contrary sample aborts a pending change.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    if (tick_pulse) begin
      case (state)
        ST_STABLE_LOW: begin
          if (btn_sync) begin
            if (LAST == ONE) begin
              state_n = ST_STABLE_HIGH;
              rise_n  = 1'b1;
            end else begin
              state_n = ST_PEND_HIGH;
              cnt_n   = ONE;
            end
          end
        end
        ST_PEND_HIGH: begin
          if (btn_sync) begin
            if (cnt_inc == LAST) begin
              state_n = ST_STABLE_HIGH;
              cnt_n   = '0;
              rise_n  = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_STABLE_LOW;
            cnt_n   = '0;
          end
        end
        ST_STABLE_HIGH: begin
          if (!btn_sync) begin
            if (LAST == ONE) begin
              state_n = ST_STABLE_LOW;
              fall_n  = 1'b1;
            end else begin
              state_n = ST_PEND_LOW;
              cnt_n   = ONE;
            end
          end
        end
        ST_PEND_LOW: begin
          if (!btn_sync) begin
            if (cnt_inc == LAST) begin
              state_n = ST_STABLE_LOW;
              cnt_n   = '0;
              fall_n  = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_STABLE_HIGH;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_STABLE_LOW;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs update together so btn_level tracks the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_STABLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      btn_level <= level_of(state_n);
      btn_rise  <= rise_n;
      btn_fall  <= fall_n;
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - randomized model-checked bench for debouncer (STABLE_COUNT 4 and 1)
module tb_debouncer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_in = 1'b1;
  logic btn_in = 1'b1;
  logic lvl4, rise4, fall4;
  logic lvl1, rise1, fall1;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  debouncer #(.STABLE_COUNT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .btn_in(btn_in),
    .btn_level(lvl4), .btn_rise(rise4), .btn_fall(fall4)
  );

  debouncer #(.STABLE_COUNT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .btn_in(btn_in),
    .btn_level(lvl1), .btn_rise(rise1), .btn_fall(fall1)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Tick source emulating a divide-by-10 clock: 5 high, 5 low; held high on request.
  logic tick_hold = 1'b1;
  int   phase = 0;
  always @(posedge clk) begin
    #1;
    if (tick_hold) begin
      tick_in = 1'b1;
      phase   = 0;
    end else begin
      phase   = (phase + 1) % 10;
      tick_in = (phase < 5);
    end
  end

  int tick_rises = 0;
  always @(posedge tick_in) tick_rises++;

  // Reference model: history of inputs seen at each clock edge since reset release.
  // A tick sample exists at edge e when tick_in was 0 then 1 at edges e-2, e-1;
  // the sampled button is the raw input seen at edge e-2 (two-flop delay).
  // The level flips once N consecutive samples disagree with it.
  bit th[$];
  bit bh[$];
  int  nlim [2] = '{4, 1};
  logic m_lvl [2];
  logic m_rise [2];
  logic m_fall [2];
  int  m_run [2];

  function automatic bit tv(input int i);
    if (i < 0) return 1'b1;
    return th[i];
  endfunction

  function automatic bit bv(input int i);
    if (i < 0) return 1'b0;
    return bh[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th.delete();
      bh.delete();
      for (int k = 0; k < 2; k++) begin
        m_lvl[k]  <= 1'b0;
        m_rise[k] <= 1'b0;
        m_fall[k] <= 1'b0;
        m_run[k]  <= 0;
      end
    end else begin
      int  e;
      bit  pul, smp, nl, r, f;
      int  nr;
      e   = th.size();
      pul = tv(e - 1) && !tv(e - 2);
      smp = bv(e - 2);
      for (int k = 0; k < 2; k++) begin
        nl = m_lvl[k];
        nr = m_run[k];
        r  = 1'b0;
        f  = 1'b0;
        if (pul) begin
          if (smp != nl) begin
            nr++;
            if (nr >= nlim[k]) begin
              r  = smp;
              f  = !smp;
              nl = smp;
              nr = 0;
            end
          end else begin
            nr = 0;
          end
        end
        m_lvl[k]  <= nl;
        m_run[k]  <= nr;
        m_rise[k] <= r;
        m_fall[k] <= f;
      end
      th.push_back(tick_in);
      bh.push_back(btn_in);
    end
  end

  // Every-cycle comparison against the model (or against reset values).
  int rise4_cnt = 0;
  int fall4_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_lvl4", lvl4, 1'b0);
      chk("reset_rise4", rise4, 1'b0);
      chk("reset_fall4", fall4, 1'b0);
      chk("reset_lvl1", lvl1, 1'b0);
    end else begin
      chk("lvl4", lvl4, m_lvl[0]);
      chk("rise4", rise4, m_rise[0]);
      chk("fall4", fall4, m_fall[0]);
      chk("lvl1", lvl1, m_lvl[1]);
      chk("rise1", rise1, m_rise[1]);
      chk("fall1", fall1, m_fall[1]);
      if (rise4) rise4_cnt++;
      if (fall4) fall4_cnt++;
    end
  end

  task automatic wait_rises(input int n);
    int target;
    int budget;
    target = tick_rises + n;
    budget = n * 12 + 20;
    while (tick_rises < target && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (tick_rises < target) begin
      n_cmp++;
      n_mis++;
      $display("FAIL tick_wait at %0t: got %0d rises expected %0d", $time, tick_rises, target);
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #3;
  endtask

  task automatic to_low_phase();
    wait_rises(1);
    repeat (6) @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    tick_hold = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    rst_n     = 1'b1;
    tick_hold = 1'b0;
  endtask

  initial begin
    btn_in = 1'b1;
    do_reset();
    repeat (4) @(posedge clk);
    #3;
    chk("no_tick_at_release_lvl1", lvl1, 1'b0);
    chk("no_tick_at_release_lvl4", lvl4, 1'b0);

    wait_rises(1);
    settle();
    chk("n1_first_tick_lvl1", lvl1, 1'b1);
    wait_rises(2);
    settle();
    chk("press_3ticks_lvl4", lvl4, 1'b0);
    wait_rises(1);
    settle();
    chk("press_4ticks_lvl4", lvl4, 1'b1);
    chk_int("press_rise_count", rise4_cnt, 1);
    chk_int("press_fall_count", fall4_cnt, 0);

    to_low_phase();
    btn_in = 1'b0;
    wait_rises(3);
    settle();
    chk("release_3ticks_lvl4", lvl4, 1'b1);
    wait_rises(1);
    settle();
    chk("release_4ticks_lvl4", lvl4, 1'b0);
    chk_int("release_fall_count", fall4_cnt, 1);

    to_low_phase();
    btn_in = 1'b1;
    wait_rises(3);
    repeat (6) @(posedge clk);
    #3;
    btn_in = 1'b0;
    wait_rises(1);
    repeat (6) @(posedge clk);
    #3;
    btn_in = 1'b1;
    wait_rises(3);
    settle();
    chk("bounce_3ticks_lvl4", lvl4, 1'b0);
    wait_rises(1);
    settle();
    chk("bounce_4ticks_lvl4", lvl4, 1'b1);
    chk_int("bounce_rise_count", rise4_cnt, 2);

    to_low_phase();
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    btn_in = 1'b1;
    wait_rises(2);
    settle();
    chk("glitch_lvl4", lvl4, 1'b1);
    chk("glitch_lvl1", lvl1, 1'b1);
    chk_int("glitch_fall_count", fall4_cnt, 1);

    to_low_phase();
    btn_in = 1'b0;
    wait_rises(5);
    settle();
    chk("pre_reset_low_lvl4", lvl4, 1'b0);
    to_low_phase();
    btn_in = 1'b1;
    wait_rises(2);
    settle();
    do_reset();
    #1;
    chk("midpend_after_reset_lvl4", lvl4, 1'b0);
    wait_rises(3);
    settle();
    chk("midpend_3ticks_lvl4", lvl4, 1'b0);
    wait_rises(1);
    settle();
    chk("midpend_4ticks_lvl4", lvl4, 1'b1);

    for (int s = 0; s < 250; s++) begin
      btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
      else repeat ($urandom_range(8, 60)) @(posedge clk);
      #3;
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 SHALL have parameter STABLE_COUNT, default 8: consecutive tick samples of equal value needed to accept a new button level; legal range 1..255.
REQ-002 SHALL have port clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port tick_in  input  1  sample strobe; the clk_out of an upstream clock_divider, registered in the clk domain.
REQ-005 SHALL have port btn_in  input  1  raw mechanical button, asynchronous to clk.
REQ-006 SHALL have port btn_level  output  1  debounced button level.
REQ-007 SHALL have port btn_rise  output  1  one-clk pulse on accepted 0->1 transition.
REQ-008 SHALL have port btn_fall  output  1  one-clk pulse on accepted 1->0 transition.

Function
REQ-009 SHALL synchronise btn_in through two flops (btn_sync); no other logic SHALL use btn_in directly.
REQ-010 SHALL derive tick_pulse, high for exactly one clk cycle, in the cycle after tick_in is sampled 0 then 1; a tick_in held high SHALL yield one pulse only.
REQ-011 SHALL sample btn_sync only in cycles where tick_pulse=1; state and counter SHALL hold otherwise.
REQ-012 SHALL implement FSM states STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
REQ-013 STABLE_LOW on tick: sample=1 -> PEND_HIGH with cnt=1 (or straight to STABLE_HIGH if STABLE_COUNT=1); sample=0 -> stay.
REQ-014 PEND_HIGH on tick: sample=1 -> cnt+1, and if cnt+1 = STABLE_COUNT -> STABLE_HIGH, cnt=0; sample=0 -> STABLE_LOW, cnt=0.
REQ-015 STABLE_HIGH and PEND_LOW SHALL mirror REQ-013/014 with sample polarity inverted, accepting into STABLE_LOW.
REQ-016 Counter width SHALL be $clog2(STABLE_COUNT+1); cnt SHALL never exceed STABLE_COUNT-1 and SHALL never wrap.
REQ-017 btn_level SHALL be a register, 1 in STABLE_HIGH and PEND_LOW, 0 in STABLE_LOW and PEND_HIGH.
REQ-018 btn_rise/btn_fall SHALL be registered and high in exactly the first clk cycle in which btn_level shows the new value; never both high in one cycle.
REQ-019 Latency: accepted edge SHALL appear on btn_level one clk after the clk edge that consumes the STABLE_COUNT-th qualifying tick_pulse.
REQ-020 A single contrary sample during PEND_* SHALL abort the pending transition with no output change and no pulse.
REQ-021 A btn_sync change between ticks SHALL be invisible; only values present in tick_pulse cycles count.

Reset
REQ-022 While rst_n=0: state=STABLE_LOW, cnt=0, btn_level=0, btn_rise=0, btn_fall=0, both sync flops=0.
REQ-023 The tick_in history flop SHALL reset to 1, so tick_in already high at reset release produces no tick_pulse.
REQ-024 Reset asserted mid-PEND_HIGH SHALL discard the count; after release a full STABLE_COUNT ticks SHALL again be required.

Structure
REQ-025 FSM state encoding (2 bits) and the tick-edge-detector interface SHALL live in shared package debounce_pkg.
REQ-026 Tick edge detection SHALL be sub-module rise_detect (clk, rst_n, din, pulse) with reset value per REQ-023; the sync chain and FSM remain in debouncer.
REQ-027 Implementation SHALL be fully synchronous apart from the async reset; no gated or derived clocks.

Verification (STABLE_COUNT=4, tick_in from clock_divider DIVISOR=10, i.e. one tick_pulse per 10 clk)
REQ-028 Reset: rst_n=0 for 10 clk with btn_in=1, tick_in=1 -> all outputs 0; first tick_pulse only after tick_in next rises.
REQ-029 Clean press: btn_in 0->1 and held -> btn_level=1 one clk after 4th post-sync tick_pulse; btn_rise high exactly 1 clk; btn_fall stays 0.
REQ-030 Bounce: btn_in 1 for 3 ticks, 0 for 1 tick, then 1 held -> no pulse until 4 further consecutive 1-samples; exactly one btn_rise.
REQ-031 Sub-tick glitch: 3-clk btn_in pulse placed between tick_pulses -> no state change, outputs unchanged.
REQ-032 Release and edge case: from STABLE_HIGH, btn_in=0 held -> btn_fall 1 clk, btn_level=0 after 4 ticks; repeat with STABLE_COUNT=1 -> transition on first tick.
REQ-033 Reset mid-pending: rst_n low after 2 qualifying ticks in PEND_HIGH -> btn_level 0, and a full 4 ticks needed after release.
